rr_bus_arbiter: RTL
===================

Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one memory/bus port among 2**N requesters.
- Each grant is held until the bus reports transaction completion, or until a watchdog timeout expires.
- Sits between the core-side masters (instruction fetch, data port, debug/DMA) and the single memory interface.
- The grant is registered, one-hot, and accompanied by a binary requester index.

Parameters:
- N, 2, log2 of requester count (2**N requesters).
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; must be >= 2.
- CW, 5, watchdog counter width; must satisfy 2**CW > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- req  input  2**N  request vector; bit i = requester i wants the bus.
- done  input  1  bus completion pulse for the current grant; ignored when not BUSY.
- grant  output  2**N  one-hot grant; all zero when idle.
- grant_id  output  N  binary index of the granted requester; 0 when idle.
- grant_valid  output  1  high while a grant is held (equals |grant).
- timeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- All outputs are registered.
- Reset (rstn low, asynchronous): state=IDLE, grant=0, grant_id=0, grant_valid=0, timeout=0, pointer=0, hold counter=0.
- Pointer: the index of the highest-priority requester. Priority order is ptr, ptr+1, ..., ptr-1 (mod 2**N).
- Selection: the first set bit of req in rotated order starting at ptr. Comb result is sel_id plus any_req.
- States:
  - IDLE:
    - If any_req at a clock edge: go to BUSY; grant<=onehot(sel_id), grant_id<=sel_id, grant_valid<=1, counter<=0.
    - Latency: request to grant is 1 cycle.
    - If no request: stay IDLE, outputs stay 0.
  - BUSY:
    - Grant is held regardless of the granted req bit; dropping req does not release the grant.
    - Counter increments each cycle.
    - On done=1: ptr<=grant_id+1 (mod 2**N), and re-arbitrate in the same edge using the updated rotation. This is zero-bubble: a new grant appears the cycle after done.
    - If no req is pending at done: go to IDLE, outputs clear.
    - The just-served requester is lowest priority, so it is re-granted only if it is the sole requester.
    - On counter==MAX_HOLD-1 with done=0: forced release. timeout<=1 for one cycle, ptr<=grant_id+1, state<=IDLE, grant cleared.
    - After a forced release there is no back-to-back grant; the next arbitration happens from IDLE the following cycle.
- Simultaneous done and watchdog expiry: done wins, no timeout pulse, normal zero-bubble handoff.
- Pointer moves only on release (done or timeout), never in IDLE.
- Wrap-around: ptr increments modulo 2**N. Example for N=2: grant_id=3 gives next ptr=0.
- timeout is 0 in every cycle except the one following a forced release.
- Reset mid-grant: grant drops immediately (asynchronous) and ptr returns to 0.
- req changes during BUSY have no effect until done or timeout.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_id matches grant when valid.

Test Plan:
- Reset then req=4'b0100 held: grant=4'b0100, grant_id=2 one cycle after req. done pulse with req still 4'b0100 gives a back-to-back re-grant to 2 (sole requester).
- req=4'b1111 constant, done pulsed every 3rd cycle: grant sequence 0,1,2,3,0 with no idle cycle between grants. Each grant lasts exactly until its done.
- Grant to 1 active, req[1] dropped and req=4'b1000 raised: grant stays 4'b0010 until done. Next cycle grant=4'b1000, grant_id=3; after done, ptr wraps to 0.
- Grant to 0 with no done for MAX_HOLD=16 cycles: timeout pulses 1 cycle, grant=0 for one cycle. Then grant goes to 1 if req=4'b0011.
- done asserted in the same cycle the counter reaches MAX_HOLD-1: timeout stays 0 and the next grant follows with no bubble.
- rstn pulsed low mid-grant to requester 2: grant, grant_valid and timeout go 0 asynchronously. After release with req=4'b1100, grant goes to 2 (ptr reset to 0).

Source files
------------

// File: rtl/rr_bus_arbiter_if.sv
// rr_bus_arbiter_if: request/grant bundle between the masters and the round-robin arbiter
interface rr_bus_arbiter_if #(parameter int N = 2);
  logic [(1<<N)-1:0] req;
  logic              done;
  logic [(1<<N)-1:0] grant;
  logic [N-1:0]      grant_id;
  logic              grant_valid;
  logic              timeout;
  modport master (output req, output done, input grant, input grant_id, input grant_valid, input timeout);
  modport slave  (input req, input done, output grant, output grant_id, output grant_valid, output timeout);
endinterface

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin bus arbiter with grant held until done or watchdog expiry
module rr_bus_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input logic              clk,
  input logic              rstn,
  rr_bus_arbiter_if.slave  bus
);
  localparam int R = 1 << N;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state, state_n;
  logic [N-1:0]  ptr, ptr_n, id_n, base, sel;
  logic [CW-1:0] cnt, cnt_n;
  logic          valid_n, timeout_n, any;
  // first requester in rotated order; on a BUSY release the rotation starts past the served requester
  always_comb begin
    base = (state == BUSY) ? bus.grant_id + N'(1) : ptr;
    sel  = '0;
    any  = 1'b0;
    for (int i = R - 1; i >= 0; i--)
      if (bus.req[base + N'(i)]) begin
        sel = base + N'(i);
        any = 1'b1;
      end
  end
  // next state: grant on request, hold until done (zero-bubble handoff) or watchdog release
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    id_n      = bus.grant_id;
    valid_n   = bus.grant_valid;
    timeout_n = 1'b0;
    if (state == IDLE) begin
      if (any) begin
        state_n = BUSY;
        id_n    = sel;
        valid_n = 1'b1;
        cnt_n   = '0;
      end
    end else begin
      cnt_n = cnt + CW'(1);
      if (bus.done) begin
        ptr_n   = bus.grant_id + N'(1);
        state_n = any ? BUSY : IDLE;
        id_n    = any ? sel : '0;
        valid_n = any;
        cnt_n   = '0;
      end else if (cnt == CW'(MAX_HOLD - 1)) begin
        ptr_n     = bus.grant_id + N'(1);
        state_n   = IDLE;
        id_n      = '0;
        valid_n   = 1'b0;
        timeout_n = 1'b1;
        cnt_n     = '0;
      end
    end
  end
  // registered state and outputs; reset clears grant immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      bus.grant       <= '0;
      bus.grant_id    <= '0;
      bus.grant_valid <= 1'b0;
      bus.timeout     <= 1'b0;
    end else begin
      state           <= state_n;
      ptr             <= ptr_n;
      cnt             <= cnt_n;
      bus.grant       <= valid_n ? {{(R-1){1'b0}}, 1'b1} << id_n : '0;
      bus.grant_id    <= id_n;
      bus.grant_valid <= valid_n;
      bus.timeout     <= timeout_n;
    end
  end
endmodule
